// File: rtl/gpu_tex_cache_pkg.sv
// Shared widths, fill-FSM encoding and address split helpers for the texture cache.
package gpu_texcache_pkg;

  localparam int TEX_ADR_W   = 19;
  localparam int LINE_ADR_W  = 17;
  localparam int MEM_ADR_W   = 18;
  localparam int MEM_DATA_W  = 32;
  localparam int LINE_BITS   = 8;
  localparam int BEATS_LOG2  = 1;
  localparam int HW_W        = 16;
  localparam int TAG_W       = TEX_ADR_W - LINE_BITS - 2;
  localparam int LINE_DATA_W = 4 * HW_W;
  localparam int RAM_W       = TAG_W + LINE_DATA_W;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_REQ  = 2'd1,
    FILL_RECV = 2'd2,
    FILL_DONE = 2'd3
  } fill_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [LINE_BITS-1:0] idx;
    logic [1:0]           off;
  } tex_adr_t;

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [LINE_BITS-1:0] idx;
  } line_adr_t;

  function automatic tex_adr_t tex_split(input logic [TEX_ADR_W-1:0] adr);
    return tex_adr_t'(adr);
  endfunction

  function automatic line_adr_t line_split(input logic [LINE_ADR_W-1:0] ladr);
    return line_adr_t'(ladr);
  endfunction

endpackage

// File: rtl/gpu_tex_cache_if.sv
// Pixel-pipe lookup/fill handshake plus VRAM read port of the texture cache.
interface gpu_tex_cache_if;
  import gpu_texcache_pkg::*;

  logic                    requDataTex_c0;
  logic [TEX_ADR_W-1:0]    adrTexReq_c0;
  logic                    TexHit_c1;
  logic                    TexMiss_c1;
  logic [HW_W-1:0]         dataTex_c1;
  logic                    requTexCacheUpdate_c1;
  logic [LINE_ADR_W-1:0]   adrTexCacheUpdate_c0;
  logic                    updateTexCacheComplete;
  logic                    i_invalidate;
  logic                    o_memReq;
  logic [MEM_ADR_W-1:0]    o_memAdr;
  logic                    i_memAck;
  logic                    i_memValid;
  logic [MEM_DATA_W-1:0]   i_memData;

  modport slave (
    input  requDataTex_c0, adrTexReq_c0, requTexCacheUpdate_c1, adrTexCacheUpdate_c0,
           i_invalidate, i_memAck, i_memValid, i_memData,
    output TexHit_c1, TexMiss_c1, dataTex_c1, updateTexCacheComplete, o_memReq, o_memAdr
  );

  modport master (
    output requDataTex_c0, adrTexReq_c0, requTexCacheUpdate_c1, adrTexCacheUpdate_c0,
           i_invalidate, i_memAck, i_memValid, i_memData,
    input  TexHit_c1, TexMiss_c1, dataTex_c1, updateTexCacheComplete, o_memReq, o_memAdr
  );
endinterface

// File: rtl/gpu_tex_cache_line_ram.sv
// 1W/1R synchronous line store (tag + 64-bit line); a same-address read sees the old word.
module tex_cache_line_ram
  import gpu_texcache_pkg::*;
(
  input  logic                 clk,
  input  logic                 i_nrst,
  input  logic                 re_i,
  input  logic [LINE_BITS-1:0] raddr_i,
  input  logic                 we_i,
  input  logic [LINE_BITS-1:0] waddr_i,
  input  logic [RAM_W-1:0]     wdata_i,
  output logic [RAM_W-1:0]     rdata_o
);

  logic [RAM_W-1:0] mem_q [2**LINE_BITS];
  logic [RAM_W-1:0] rd_q;

  // Array write port; contents need no reset because valid bits live outside.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, cleared so the texel output is zero out of reset.
  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      rd_q <= {RAM_W{1'b0}};
    end else if (re_i) begin
      rd_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rd_q;

endmodule

// File: rtl/gpu_tex_cache.sv
// Direct-mapped texture cache: 1-cycle lookup and 2-beat VRAM line fill.
// Optional hit/miss/fill counters when GPU_TEXCACHE_STATS_EN is defined.
module gpu_tex_cache
  import gpu_texcache_pkg::*;
(
  input  logic             clk,
  input  logic             i_nrst,
  gpu_tex_cache_if.slave   bus
`ifdef GPU_TEXCACHE_STATS_EN
  ,
  output logic [31:0]      o_statHit,
  output logic [31:0]      o_statMiss,
  output logic [15:0]      o_statFill
`endif
);

  tex_adr_t                req_adr_s;
  line_adr_t               fill_adr_s;
  logic [2**LINE_BITS-1:0] valid_q;
  logic                    req_c1_q;
  logic                    valid_c1_q;
  logic [TAG_W-1:0]        tag_c1_q;
  logic [1:0]              off_c1_q;
  logic [RAM_W-1:0]        rd_s;
  logic                    hit_s;
  logic [HW_W-1:0]         texel_s;

  fill_state_e             state_q, state_d;
  logic [LINE_ADR_W-1:0]   line_adr_q, line_adr_d;
  logic [BEATS_LOG2-1:0]   beat_q, beat_d;
  logic [MEM_DATA_W-1:0]   lo_q, lo_d;
  logic                    discard_q, discard_d;
  logic                    line_we_s;
  logic                    set_valid_s;

  assign req_adr_s  = tex_split(bus.adrTexReq_c0);
  assign fill_adr_s = line_split(line_adr_q);

  tex_cache_line_ram u_ram (
    .clk     (clk),
    .i_nrst  (i_nrst),
    .re_i    (bus.requDataTex_c0),
    .raddr_i (req_adr_s.idx),
    .we_i    (line_we_s),
    .waddr_i (fill_adr_s.idx),
    .wdata_i ({fill_adr_s.tag, bus.i_memData, lo_q}),
    .rdata_o (rd_s)
  );

  // c0 -> c1 lookup pipeline; valid is sampled before any same-edge line write.
  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      req_c1_q   <= 1'b0;
      valid_c1_q <= 1'b0;
      tag_c1_q   <= {TAG_W{1'b0}};
      off_c1_q   <= 2'd0;
    end else begin
      req_c1_q <= bus.requDataTex_c0;
      if (bus.requDataTex_c0) begin
        valid_c1_q <= valid_q[req_adr_s.idx];
        tag_c1_q   <= req_adr_s.tag;
        off_c1_q   <= req_adr_s.off;
      end
    end
  end

  assign hit_s = req_c1_q & valid_c1_q & (rd_s[RAM_W-1:LINE_DATA_W] == tag_c1_q);

  // Halfword select within the 64-bit line; halfword 0 is the lowest VRAM address.
  always_comb begin
    texel_s = {HW_W{1'b0}};
    case (off_c1_q)
      2'd0:    texel_s = rd_s[15:0];
      2'd1:    texel_s = rd_s[31:16];
      2'd2:    texel_s = rd_s[47:32];
      2'd3:    texel_s = rd_s[63:48];
      default: texel_s = {HW_W{1'b0}};
    endcase
  end

  assign bus.TexHit_c1  = hit_s;
  assign bus.TexMiss_c1 = req_c1_q & ~hit_s;
  assign bus.dataTex_c1 = texel_s;

  // Valid flags: invalidate clears everything and beats a same-cycle line commit.
  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      valid_q <= {(2**LINE_BITS){1'b0}};
    end else if (bus.i_invalidate) begin
      valid_q <= {(2**LINE_BITS){1'b0}};
    end else if (set_valid_s) begin
      valid_q[fill_adr_s.idx] <= 1'b1;
    end
  end

  // Fill FSM state registers.
  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      state_q    <= FILL_IDLE;
      line_adr_q <= {LINE_ADR_W{1'b0}};
      beat_q     <= {BEATS_LOG2{1'b0}};
      lo_q       <= {MEM_DATA_W{1'b0}};
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_adr_q <= line_adr_d;
      beat_q     <= beat_d;
      lo_q       <= lo_d;
      discard_q  <= discard_d;
    end
  end

  // Fill FSM next state; an invalidate while the line is in flight marks it discard.
  always_comb begin
    state_d     = state_q;
    line_adr_d  = line_adr_q;
    beat_d      = beat_q;
    lo_d        = lo_q;
    discard_d   = discard_q;
    line_we_s   = 1'b0;
    set_valid_s = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        discard_d = 1'b0;
        beat_d    = {BEATS_LOG2{1'b0}};
        if (bus.requTexCacheUpdate_c1) begin
          line_adr_d = bus.adrTexCacheUpdate_c0;
          state_d    = FILL_REQ;
        end else begin
          state_d = FILL_IDLE;
        end
      end
      FILL_REQ: begin
        if (bus.i_invalidate) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
        if (bus.i_memAck) begin
          state_d = FILL_RECV;
        end else begin
          state_d = FILL_REQ;
        end
      end
      FILL_RECV: begin
        if (bus.i_invalidate) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
        if (bus.i_memValid && (beat_q != {BEATS_LOG2{1'b1}})) begin
          lo_d   = bus.i_memData;
          beat_d = beat_q + 1'b1;
        end else if (bus.i_memValid) begin
          line_we_s   = 1'b1;
          set_valid_s = ~discard_q & ~bus.i_invalidate;
          state_d     = FILL_DONE;
        end else begin
          state_d = FILL_RECV;
        end
      end
      FILL_DONE: begin
        state_d = FILL_IDLE;
      end
      default: begin
        state_d = FILL_IDLE;
      end
    endcase
  end

  assign bus.o_memReq               = (state_q == FILL_REQ);
  assign bus.o_memAdr               = {line_adr_q, 1'b0};
  assign bus.updateTexCacheComplete = (state_q == FILL_DONE);

`ifdef GPU_TEXCACHE_STATS_EN
  logic [31:0] stat_hit_q, stat_miss_q;
  logic [15:0] stat_fill_q;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      stat_hit_q  <= 32'd0;
      stat_miss_q <= 32'd0;
      stat_fill_q <= 16'd0;
    end else begin
      if (hit_s && (stat_hit_q != 32'hFFFF_FFFF)) begin
        stat_hit_q <= stat_hit_q + 32'd1;
      end
      if (bus.TexMiss_c1 && (stat_miss_q != 32'hFFFF_FFFF)) begin
        stat_miss_q <= stat_miss_q + 32'd1;
      end
      if (bus.updateTexCacheComplete && (stat_fill_q != 16'hFFFF)) begin
        stat_fill_q <= stat_fill_q + 16'd1;
      end
    end
  end

  assign o_statHit  = stat_hit_q;
  assign o_statMiss = stat_miss_q;
  assign o_statFill = stat_fill_q;
`endif

endmodule
